// File: rtl/reg_rename_file_if.sv
// rtl/reg_rename_file_if.sv - dispatch/commit/read bundle for the rename register file
// master = dispatch + ROB side, slave = register file.
interface reg_rename_file_if #(
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32,
  parameter int ROB_W      = 4,
  parameter int READ_PORTS = 2
);
  logic                           rdy;
  logic                           flush;
  logic                           commit_en;
  logic [REG_ADDR_W-1:0]          commit_rd;
  logic [ROB_W-1:0]               commit_tag;
  logic [XLEN-1:0]                commit_data;
  logic                           rename_en;
  logic [REG_ADDR_W-1:0]          rename_rd;
  logic [ROB_W-1:0]               rename_tag;
  logic [READ_PORTS*REG_ADDR_W-1:0] rs_addr;
  logic [READ_PORTS*XLEN-1:0]     rs_value;
  logic [READ_PORTS-1:0]          rs_busy;
  logic [READ_PORTS*ROB_W-1:0]    rs_tag;
  logic [REG_ADDR_W:0]            busy_count;

  modport master (
    output rdy, flush, commit_en, commit_rd, commit_tag, commit_data,
           rename_en, rename_rd, rename_tag, rs_addr,
    input  rs_value, rs_busy, rs_tag, busy_count
  );

  modport slave (
    input  rdy, flush, commit_en, commit_rd, commit_tag, commit_data,
           rename_en, rename_rd, rename_tag, rs_addr,
    output rs_value, rs_busy, rs_tag, busy_count
  );
endinterface

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with busy/ROB-tag rename state
// Reads are combinational with commit forwarding; busy_count is a registered popcount.
module reg_rename_file #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32,
  parameter int ROB_W      = 4,
  parameter int READ_PORTS = 2
) (
  input logic               clk,
  input logic               rst,
  reg_rename_file_if.slave  bus
);
  localparam int CNT_W = REG_ADDR_W + 1;

  logic [XLEN-1:0]              r_value [REG_NUM];
  logic [ROB_W-1:0]             r_tag   [REG_NUM];
  logic [REG_NUM-1:0]           r_busy;
  logic [CNT_W-1:0]             r_busy_count;

  logic                         w_commit_do;
  logic                         w_commit_clr;
  logic                         w_rename_do;
  logic [REG_NUM-1:0]           w_busy_next;
  logic [CNT_W-1:0]             w_busy_pop;

  logic [REG_ADDR_W-1:0]        w_addr;
  logic                         w_fwd;
  logic [READ_PORTS*XLEN-1:0]   w_rs_value;
  logic [READ_PORTS-1:0]        w_rs_busy;
  logic [READ_PORTS*ROB_W-1:0]  w_rs_tag;

  // Next busy vector: flush clears everything, else a rename beats a matching commit.
  always_comb begin
    w_commit_do  = bus.commit_en && (bus.commit_rd != '0);
    w_commit_clr = w_commit_do && r_busy[bus.commit_rd] &&
                   (r_tag[bus.commit_rd] == bus.commit_tag);
    w_rename_do  = bus.rename_en && !bus.flush && (bus.rename_rd != '0);
    w_busy_next  = r_busy;
    if (bus.flush) begin
      w_busy_next = '0;
    end else begin
      if (w_commit_clr) w_busy_next[bus.commit_rd] = 1'b0;
      if (w_rename_do)  w_busy_next[bus.rename_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
    w_busy_pop = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      w_busy_pop = w_busy_pop + CNT_W'(w_busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_busy       <= '0;
      r_busy_count <= '0;
    end else if (bus.rdy) begin
      if (w_commit_do) r_value[bus.commit_rd] <= bus.commit_data;
      if (w_rename_do) r_tag[bus.rename_rd]   <= bus.rename_tag;
      r_busy       <= w_busy_next;
      r_busy_count <= w_busy_pop;
    end
  end

  // Same-cycle renames are deliberately invisible here; only a matching commit forwards.
  always_comb begin
    w_rs_value = '0;
    w_rs_busy  = '0;
    w_rs_tag   = '0;
    w_addr     = '0;
    w_fwd      = 1'b0;
    for (int k = 0; k < READ_PORTS; k++) begin
      w_addr = bus.rs_addr[k*REG_ADDR_W +: REG_ADDR_W];
      w_fwd  = bus.rdy && bus.commit_en && (bus.commit_rd == w_addr) &&
               r_busy[w_addr] && (r_tag[w_addr] == bus.commit_tag);
      if (w_addr != '0) begin
        w_rs_value[k*XLEN +: XLEN]  = w_fwd ? bus.commit_data : r_value[w_addr];
        w_rs_busy[k]                = r_busy[w_addr] && !w_fwd;
        w_rs_tag[k*ROB_W +: ROB_W]  = r_tag[w_addr];
      end
    end
  end

  assign bus.rs_value   = w_rs_value;
  assign bus.rs_busy    = w_rs_busy;
  assign bus.rs_tag     = w_rs_tag;
  assign bus.busy_count = r_busy_count;
endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - directed table plus randomized model check of reg_rename_file
module tb_reg_rename_file;
  localparam int REG_NUM = 32;
  localparam int AW      = 5;
  localparam int XLEN    = 32;
  localparam int RW      = 4;
  localparam int RP      = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_rename_file_if #(.REG_ADDR_W(AW), .XLEN(XLEN), .ROB_W(RW), .READ_PORTS(RP)) bus ();

  reg_rename_file #(.REG_NUM(REG_NUM), .REG_ADDR_W(AW), .XLEN(XLEN), .ROB_W(RW),
                    .READ_PORTS(RP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] m_value [REG_NUM];
  logic [RW-1:0]   m_tag   [REG_NUM];
  bit              m_busy  [REG_NUM];

  typedef struct {
    logic            rdy, flush, cen;
    logic [AW-1:0]   crd;
    logic [RW-1:0]   ctag;
    logic [XLEN-1:0] cdata;
    logic            ren;
    logic [AW-1:0]   rrd;
    logic [RW-1:0]   rtag;
    logic [AW-1:0]   a0, a1;
    logic [XLEN-1:0] v0;
    logic            b0;
    logic [RW-1:0]   t0;
    logic [XLEN-1:0] v1;
    logic            b1;
    logic [RW-1:0]   t1;
    int              cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(int rdy, int flush, int cen, int crd, int ctag, logic [31:0] cdata,
                              int ren, int rrd, int rtag, int a0, int a1,
                              logic [31:0] v0, int b0, int t0, logic [31:0] v1, int b1, int t1,
                              int cnt);
    vec_t v;
    v.rdy = (rdy != 0); v.flush = (flush != 0); v.cen = (cen != 0);
    v.crd = AW'(crd); v.ctag = RW'(ctag); v.cdata = cdata;
    v.ren = (ren != 0); v.rrd = AW'(rrd); v.rtag = RW'(rtag);
    v.a0 = AW'(a0); v.a1 = AW'(a1);
    v.v0 = v0; v.b0 = (b0 != 0); v.t0 = RW'(t0);
    v.v1 = v1; v.b1 = (b1 != 0); v.t1 = RW'(t1);
    v.cnt = cnt;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic flush, input logic cen, input logic [AW-1:0] crd,
                       input logic [RW-1:0] ctag, input logic [XLEN-1:0] cdata, input logic ren,
                       input logic [AW-1:0] rrd, input logic [RW-1:0] rtag,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rdy = rdy; bus.flush = flush;
    bus.commit_en = cen; bus.commit_rd = crd; bus.commit_tag = ctag; bus.commit_data = cdata;
    bus.rename_en = ren; bus.rename_rd = rrd; bus.rename_tag = rtag;
    bus.rs_addr = {a1, a0};
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_value[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < REG_NUM; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Rules applied at a clock edge, in the order the behaviour is described.
  task automatic model_edge();
    int  c, r;
    bit  matched;
    if (!bus.rdy) return;
    c = int'(bus.commit_rd);
    r = int'(bus.rename_rd);
    matched = bus.commit_en && c != 0 && m_busy[c] && m_tag[c] == bus.commit_tag;
    if (bus.commit_en && c != 0) m_value[c] = bus.commit_data;
    if (bus.flush) begin
      for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
    end else begin
      if (matched) m_busy[c] = 1'b0;
      if (bus.rename_en && r != 0) begin
        m_busy[r] = 1'b1;
        m_tag[r]  = bus.rename_tag;
      end
    end
  endtask

  task automatic check_reads(input string name);
    int              r;
    logic [XLEN-1:0] ev;
    logic            eb;
    logic [RW-1:0]   et;
    for (int k = 0; k < RP; k++) begin
      r  = int'(bus.rs_addr[k*AW +: AW]);
      ev = '0; eb = 1'b0; et = '0;
      if (r != 0) begin
        ev = m_value[r]; eb = m_busy[r]; et = m_tag[r];
        if (bus.rdy && bus.commit_en && int'(bus.commit_rd) == r && m_busy[r] &&
            m_tag[r] == bus.commit_tag) begin
          ev = bus.commit_data; eb = 1'b0;
        end
      end
      chk($sformatf("%s value x%0d", name, r), bus.rs_value[k*XLEN +: XLEN], ev);
      chk($sformatf("%s busy x%0d", name, r), 32'(bus.rs_busy[k]), 32'(eb));
      if (eb) chk($sformatf("%s tag x%0d", name, r), 32'(bus.rs_tag[k*RW +: RW]), 32'(et));
    end
  endtask

  task automatic run_cycle(input string name);
    #1 check_reads(name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk({name, " busy_count"}, 32'(bus.busy_count), 32'(model_count()));
  endtask

  task automatic reset_seq();
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), RW'($urandom), $urandom,
            1'($urandom), AW'($urandom), RW'($urandom), AW'($urandom), AW'($urandom));
      #1 chk("in-reset busy_count", 32'(bus.busy_count), 32'd0);
      chk("in-reset value", bus.rs_value[XLEN-1:0], 32'd0);
      @(negedge clk);
    end
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int r = 0; r < REG_NUM; r += 2) begin
      bus.rs_addr = {AW'(r + 1), AW'(r)};
      #1 chk("post-reset value even", bus.rs_value[XLEN-1:0], 32'd0);
      chk("post-reset value odd", bus.rs_value[2*XLEN-1:XLEN], 32'd0);
      chk("post-reset busy", 32'(bus.rs_busy), 32'd0);
      @(negedge clk);
    end
    chk("post-reset busy_count", 32'(bus.busy_count), 32'd0);
  endtask

  initial begin
    int  crd;
    bit  seen_flush;
    vec_t v;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    reset_seq();

    //   rdy fl cen crd ctag data          ren rrd rtag a0 a1  v0            b0 t0 v1            b1 t1 cnt
    add(1, 0, 0, 0, 0, 32'h0,          1, 5, 3,  5, 7,  32'h0,        0, 0, 32'h0,        0, 0, 1);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0,  5, 0,  32'h0,        1, 3, 32'h0,        0, 0, 1);
    add(1, 0, 1, 5, 3, 32'hDEADBEEF,   0, 0, 0,  5, 5,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,          1, 7, 2,  5, 7,  32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 1);
    add(1, 0, 0, 0, 0, 32'h0,          1, 7, 6,  7, 5,  32'h0,        1, 2, 32'hDEADBEEF, 0, 0, 1);
    add(1, 0, 1, 7, 2, 32'h11,         0, 0, 0,  7, 7,  32'h0,        1, 6, 32'h0,        1, 6, 1);
    add(1, 0, 1, 7, 6, 32'h22,         0, 0, 0,  7, 7,  32'h22,       0, 0, 32'h22,       0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,          1, 9, 1,  7, 9,  32'h22,       0, 0, 32'h0,        0, 0, 1);
    add(1, 0, 1, 9, 1, 32'h55,         1, 9, 4,  9, 7,  32'h55,       0, 0, 32'h22,       0, 0, 1);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0,  9, 7,  32'h55,       1, 4, 32'h22,       0, 0, 1);
    add(1, 0, 0, 0, 0, 32'h0,          1, 1, 0,  9, 1,  32'h55,       1, 4, 32'h0,        0, 0, 2);
    add(1, 0, 0, 0, 0, 32'h0,          1, 2, 1,  9, 1,  32'h55,       1, 4, 32'h0,        1, 0, 3);
    add(1, 0, 0, 0, 0, 32'h0,          1, 3, 2,  2, 1,  32'h0,        1, 1, 32'h0,        1, 0, 4);
    add(1, 0, 0, 0, 0, 32'h0,          1, 4, 3,  3, 4,  32'h0,        1, 2, 32'h0,        0, 0, 5);
    add(1, 1, 1, 2, 1, 32'h77,         1, 8, 5,  2, 8,  32'h77,       0, 0, 32'h0,        0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0,  2, 8,  32'h77,       0, 0, 32'h0,        0, 0, 0);
    add(1, 0, 1, 0, 0, 32'hFFFFFFFF,   1, 0, 7,  0, 0,  32'h0,        0, 0, 32'h0,        0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,          1, 3, 9,  0, 3,  32'h0,        0, 0, 32'h0,        0, 0, 1);
    add(0, 0, 1, 3, 9, 32'h99,         1, 6, 1,  3, 6,  32'h0,        1, 9, 32'h0,        0, 0, 1);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0,  3, 6,  32'h0,        1, 9, 32'h0,        0, 0, 1);
    add(1, 0, 1, 3, 9, 32'h99,         0, 0, 0,  3, 9,  32'h99,       0, 0, 32'h55,       0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.rdy, v.flush, v.cen, v.crd, v.ctag, v.cdata, v.ren, v.rrd, v.rtag, v.a0, v.a1);
      #1;
      chk($sformatf("vec%0d p0 value", i), bus.rs_value[XLEN-1:0], v.v0);
      chk($sformatf("vec%0d p0 busy", i), 32'(bus.rs_busy[0]), 32'(v.b0));
      if (v.b0) chk($sformatf("vec%0d p0 tag", i), 32'(bus.rs_tag[RW-1:0]), 32'(v.t0));
      chk($sformatf("vec%0d p1 value", i), bus.rs_value[2*XLEN-1:XLEN], v.v1);
      chk($sformatf("vec%0d p1 busy", i), 32'(bus.rs_busy[1]), 32'(v.b1));
      if (v.b1) chk($sformatf("vec%0d p1 tag", i), 32'(bus.rs_tag[2*RW-1:RW]), 32'(v.t1));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk($sformatf("vec%0d busy_count", i), 32'(bus.busy_count), 32'(v.cnt));
    end

    // Asynchronous reset dropped between edges must clear state before the next edge.
    drive(1, 0, 0, 0, 0, 0, 1, 10, 2, 5, 10);
    run_cycle("pre-async");
    drive(1, 0, 1, 5, 0, 32'h1234, 0, 0, 0, 5, 10);
    #2 rst = 1'b0;
    #1 chk("async value x5", bus.rs_value[XLEN-1:0], 32'd0);
    chk("async busy x10", 32'(bus.rs_busy[1]), 32'd0);
    chk("async busy_count", 32'(bus.busy_count), 32'd0);
    @(negedge clk);
    reset_seq();

    seen_flush = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      crd = $urandom_range(0, 11);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0), 1'($urandom), AW'(crd),
            ($urandom_range(0, 1) != 0) ? m_tag[crd] : RW'($urandom), $urandom,
            1'($urandom), AW'($urandom_range(0, 11)), RW'($urandom),
            ($urandom_range(0, 1) != 0) ? AW'(crd) : AW'($urandom_range(0, 11)),
            AW'($urandom_range(0, 11)));
      if (bus.flush) seen_flush = 1'b1;
      run_cycle("rand");
    end
    chk("random flush exercised", 32'(seen_flush), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
